// File: rtl/relu_stream_ctrl_pkg.sv
// rtl/relu_stream_ctrl_pkg.sv - shared types, widths and element function for the activation stage
package relu_stream_ctrl_pkg;

  localparam int FM_W       = 5;
  localparam int FM_H       = 5;
  localparam int DATA_W     = 16;
  localparam int ELEM_CNT_W = $clog2(FM_W * FM_H);
  localparam int NEG_CNT_W  = $clog2(FM_W * FM_H + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Shared with the parallel ReLU unit: negative elements clip to zero unless bypassed.
  function automatic logic [DATA_W-1:0] relu_elem(input logic [DATA_W-1:0] elem,
                                                  input logic             bypass);
    return (!bypass && elem[DATA_W-1]) ? '0 : elem;
  endfunction

endpackage

// File: rtl/relu_stream_ctrl_if.sv
// rtl/relu_stream_ctrl_if.sv - input and output element handshakes of the activation stage
interface relu_stream_ctrl_if
  import relu_stream_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W
);

  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport slave  (input  s_valid, s_data, m_ready,
                  output s_ready, m_valid, m_data, m_last);

  modport master (output s_valid, s_data, m_ready,
                  input  s_ready, m_valid, m_data, m_last);

endinterface

// File: rtl/relu_out_reg.sv
// rtl/relu_out_reg.sv - single valid/ready output register for the activation stream
module relu_out_reg #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  input  logic                  m_ready,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;

  // load is only raised when the register is empty or being drained, so a stalled word never changes
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      last_d  = load_last;
    end else if (valid_q && m_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign m_valid = valid_q;
  assign m_data  = data_q;
  assign m_last  = last_q;

endmodule

// File: rtl/relu_stream_ctrl.sv
// rtl/relu_stream_ctrl.sv - frame sequencer applying ReLU or bypass one element per cycle
module relu_stream_ctrl
  import relu_stream_ctrl_pkg::*;
#(
  parameter int W          = FM_W,
  parameter int H          = FM_H,
  parameter int DATA_WIDTH = DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 bypass,
  relu_stream_ctrl_if.slave    io,
  output logic                 busy,
  output logic                 done,
  output logic [NEG_CNT_W-1:0] neg_count
);

  localparam logic [ELEM_CNT_W-1:0] LAST_IDX = ELEM_CNT_W'(W * H - 1);

  state_e                  state_q, state_d;
  logic                    mode_q, mode_d;
  logic [ELEM_CNT_W-1:0]   elem_cnt_q, elem_cnt_d;
  logic [NEG_CNT_W-1:0]    neg_cnt_q, neg_cnt_d;
  logic                    s_ready;
  logic                    accept;
  logic                    m_valid;
  logic                    m_last;
  logic [DATA_WIDTH-1:0]   m_data;
  logic [DATA_WIDTH-1:0]   elem_out;

  assign accept   = io.s_valid && s_ready;
  assign elem_out = relu_elem(io.s_data, mode_q);

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    elem_cnt_d = elem_cnt_q;
    neg_cnt_d  = neg_cnt_q;
    s_ready    = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d     = bypass;
          elem_cnt_d = '0;
          neg_cnt_d  = '0;
          state_d    = RUN;
        end
      end
      RUN: begin
        s_ready = !m_valid || io.m_ready;
        if (s_ready && io.s_valid) begin
          elem_cnt_d = elem_cnt_q + 1'b1;
          if (io.s_data[DATA_WIDTH-1]) neg_cnt_d = neg_cnt_q + 1'b1;
          if (elem_cnt_q == LAST_IDX) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (m_valid && io.m_ready && m_last) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      elem_cnt_q <= '0;
      neg_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      elem_cnt_q <= elem_cnt_d;
      neg_cnt_q  <= neg_cnt_d;
    end
  end

  relu_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_data(elem_out),
    .load_last(elem_cnt_q == LAST_IDX),
    .m_ready  (io.m_ready),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_last   (m_last)
  );

  assign io.s_ready = s_ready;
  assign io.m_valid = m_valid;
  assign io.m_data  = m_data;
  assign io.m_last  = m_last;
  assign busy       = (state_q != IDLE);
  assign neg_count  = neg_cnt_q;

endmodule

// File: tb/tb_relu_stream_ctrl.sv
// tb/tb_relu_stream_ctrl.sv - scoreboard bench for relu_stream_ctrl with directed frames
module tb_relu_stream_ctrl;
  import relu_stream_ctrl_pkg::*;

  localparam int N = 25;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 bypass;
  logic                 busy;
  logic                 done;
  logic [NEG_CNT_W-1:0] neg_count;

  relu_stream_ctrl_if #(.DATA_WIDTH(16)) sif ();

  relu_stream_ctrl #(.W(5), .H(5), .DATA_WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bypass   (bypass),
    .io       (sif),
    .busy     (busy),
    .done     (done),
    .neg_count(neg_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int acc_cyc = 0;
  int first_acc_cyc = 0;

  logic [15:0] in_v [N];
  logic [15:0] ex_v [N];
  logic [16:0] exp_q [$];
  logic [16:0] e;
  logic        hold_v = 1'b0;
  logic [15:0] hold_d;
  logic        hold_l;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on each output handshake and guards stall stability.
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("hold_valid", sif.m_valid, 1);
        check("hold_data", sif.m_data, hold_d);
        check("hold_last", sif.m_last, hold_l);
      end
      if (sif.m_valid && !sif.m_ready) check("s_ready_stall", sif.s_ready, 0);
      if (sif.m_valid && sif.m_ready) begin
        check("scoreboard_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_data", sif.m_data, e[16:1]);
          check("out_last", sif.m_last, e[0]);
        end
        check("done_on_handshake", done, sif.m_last);
      end else begin
        check("done_quiet", done, 0);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      hold_v = sif.m_valid && !sif.m_ready;
      hold_d = sif.m_data;
      hold_l = sif.m_last;
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_m_valid"}, sif.m_valid, 0);
    check({tag, "_m_data"}, sif.m_data, 0);
    check({tag, "_m_last"}, sif.m_last, 0);
    check({tag, "_s_ready"}, sif.s_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_neg_count"}, neg_count, 0);
  endtask

  task automatic send(input logic [15:0] d, input logic [15:0] ed, input logic el);
    int t;
    bit ok;
    t  = 0;
    ok = 1'b0;
    sif.s_valid = 1'b1;
    sif.s_data  = d;
    while (!ok && t < 50) begin
      @(negedge clk);
      if (sif.s_ready) begin
        exp_q.push_back({ed, el});
        acc_cyc = cyc;
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
      t++;
    end
    sif.s_valid = 1'b0;
    check("accept_timeout", ok, 1);
  endtask

  task automatic run_frame(input logic md, input int exp_neg, input int stall_at,
                           input int start_at, input int reset_at,
                           input int mid_i, input int mid_neg, input bit time_it);
    int d0;
    int t;
    int n0;
    d0     = done_cnt;
    start  = 1'b1;
    bypass = md;
    check("no_residual_valid", sif.m_valid, 0);
    @(posedge clk);
    #1;
    start  = 1'b0;
    bypass = 1'b0;
    check("busy_after_start", busy, 1);
    for (int i = 0; i < N; i++) begin
      if (i == reset_at) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset("midrst");
        rst = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        check("no_done_after_reset", done_cnt, d0);
        return;
      end
      if (i == start_at) begin
        n0     = neg_count;
        start  = 1'b1;
        bypass = ~md;
        @(posedge clk);
        #1;
        start  = 1'b0;
        bypass = 1'b0;
        check("spurious_start_neg", neg_count, n0);
        check("spurious_start_busy", busy, 1);
      end
      if (i == stall_at) begin
        fork
          begin
            sif.m_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            sif.m_ready = 1'b1;
          end
        join_none
      end
      send(in_v[i], ex_v[i], i == N - 1);
      if (i == 0) first_acc_cyc = acc_cyc;
      if (i == mid_i) check("neg_count_mid", neg_count, mid_neg);
    end
    t = 0;
    while (done_cnt == d0 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("done_once", done_cnt - d0, 1);
    if (time_it) check("frame_latency", done_cyc - first_acc_cyc, 25);
    check("neg_count_final", neg_count, exp_neg);
    check("busy_after_done", busy, 0);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic load_alt(input logic md);
    for (int i = 0; i < N; i++) begin
      in_v[i] = (i % 2 == 0) ? 16'hFFFF : 16'h0FFF;
      ex_v[i] = md ? in_v[i] : ((i % 2 == 0) ? 16'h0000 : 16'h0FFF);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    bypass      = 1'b0;
    sif.s_valid = 1'b0;
    sif.s_data  = '0;
    sif.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    load_alt(1'b0);
    run_frame(1'b0, 13, -1, -1, -1, 0, 1, 1'b1);

    load_alt(1'b1);
    run_frame(1'b1, 13, -1, -1, -1, -1, 0, 1'b0);

    in_v[0] = 16'h8000; ex_v[0] = 16'h0000;
    in_v[1] = 16'h0000; ex_v[1] = 16'h0000;
    in_v[2] = 16'h7FFF; ex_v[2] = 16'h7FFF;
    in_v[3] = 16'hFFFF; ex_v[3] = 16'h0000;
    for (int i = 4; i < N; i++) begin
      in_v[i] = 16'h0001;
      ex_v[i] = 16'h0001;
    end
    run_frame(1'b0, 2, -1, -1, -1, 3, 2, 1'b0);

    for (int i = 0; i < N; i++) begin
      in_v[i] = 16'h0100 + 16'(i);
      ex_v[i] = 16'h0100 + 16'(i);
    end
    run_frame(1'b0, 0, 10, -1, -1, -1, 0, 1'b0);

    load_alt(1'b0);
    run_frame(1'b0, 13, -1, 7, -1, -1, 0, 1'b0);

    run_frame(1'b0, 0, -1, -1, 10, -1, 0, 1'b0);

    load_alt(1'b0);
    run_frame(1'b0, 13, -1, -1, -1, -1, 0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/relu_stream_ctrl.md
# relu_stream_ctrl

Sequencer for the activation stage. It accepts one W×H feature map as a stream of DATA_WIDTH-bit signed elements and applies ReLU one element per cycle, or passes elements through unchanged in bypass mode. It drives a registered output stream that marks the last element of the frame and counts clipped (negative) elements. It sits between the convolution output buffer and the next layer's input buffer, and replaces the fully parallel W*H-wide combinational ReLU where that width is too costly.

## Interface
- W, 5, feature-map width in elements
- H, 5, feature-map height in elements
- DATA_WIDTH, 16, element width, two's complement
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; starts a frame when in IDLE
- bypass  in  1  sampled with start; 1 = pass through, 0 = ReLU
- s_valid  in  1  input element valid
- s_ready  out  1  input element accepted when s_valid && s_ready
- s_data  in  DATA_WIDTH  input element, raster order
- m_valid  out  1  output element valid
- m_ready  in  1  downstream accepts when m_valid && m_ready
- m_data  out  DATA_WIDTH  output element
- m_last  out  1  high with the frame's final element (index W*H-1)
- busy  out  1  high when state is not IDLE
- done  out  1  one-cycle pulse after the last element is consumed
- neg_count  out  clog2(W*H+1)  number of negative inputs in the current or last frame

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - s_ready=0.
  - start=1 latches bypass into mode_q, clears elem_cnt and neg_count, and moves to RUN.
  - start is ignored in RUN and DRAIN.
- RUN:
  - s_ready = !m_valid || m_ready (single output register, no skid).
  - On accept: m_data <= (mode_q==0 && s_data[MSB]) ? 0 : s_data; m_valid <= 1; m_last <= (elem_cnt==W*H-1); elem_cnt++.
  - neg_count++ when s_data[MSB]=1, independent of mode.
  - The accept of element W*H-1 moves the FSM to DRAIN.
- DRAIN:
  - s_ready=0.
  - When m_valid && m_ready && m_last: done=1 for that cycle; next state IDLE.
- Output register:
  - On m_valid && m_ready with no new accept in the same cycle: m_valid <= 0.
  - Simultaneous consume and accept: m_valid stays 1 and m_data is replaced.
- ReLU rule:
  - Zero is non-negative.
  - The most negative value (1 followed by zeros) outputs 0.
  - Output width equals input width; there is no saturation or scaling.
- neg_count holds its value after done until the next start.
- Reset mid-frame discards the frame. No done is issued.

## Timing
- Reset values: state=IDLE, s_ready=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0, neg_count=0, elem_cnt=0, mode_q=0.
- start cycle N: busy=1 from N+1. s_ready can be 1 from N+1.
- Latency: element accepted at cycle N appears on m_data/m_valid at N+1.
- Throughput is 1 element/cycle with m_ready held high. A W*H=25 frame starting at the first accept at cycle N ends with done at cycle N+25, assuming m_ready=1.
- done is asserted combinationally in the same cycle as the final output handshake. busy drops at the following edge.
- m_data, m_valid and m_last must stay stable while m_valid && !m_ready.
- s_valid may toggle freely. Gaps stall elem_cnt without error.

## Structure
- The shared activation package holds:
  - FSM state enum (IDLE/RUN/DRAIN)
  - ELEM_CNT_W = clog2(W*H)
  - NEG_CNT_W = clog2(W*H+1)
  - a relu_elem function (element in, mode in, element out), reused by the parallel ReLU unit
- One sub-module, relu_out_reg: the valid/ready output register holding m_data, m_valid and m_last. The FSM and counters stay in the top module.

## Test plan
- ReLU frame: start with bypass=0, alternating inputs 0xFFFF, 0x0FFF for 25 elements, m_ready=1 -> outputs alternate 0x0000, 0x0FFF; m_last only on element 24; done one cycle on the last handshake; neg_count=13.
- Bypass: same stream with bypass=1 -> outputs equal inputs; neg_count=13.
- Boundary values: inputs 0x8000, 0x0000, 0x7FFF, 0xFFFF -> outputs 0x0000, 0x0000, 0x7FFF, 0x0000; neg_count increments for 0x8000 and 0xFFFF only.
- Backpressure: m_ready low for 3 cycles mid-frame -> m_data stable, s_ready=0 while the register is full, no element lost or duplicated, order preserved.
- Protocol: start pulsed during RUN is ignored, and elem_cnt and neg_count are unchanged. Starting a new frame right after done works with no residual m_valid.
- Reset mid-frame after 10 elements -> all outputs at reset values the next cycle, no done; a new start then runs a full 25-element frame correctly.
